// File: rtl/instruction_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instruction_queue_pkg                                      |
// | Description : Shared types and constants for the fetch-to-dispatch       |
// |               instruction queue. pipe_in_t is the Fetch->Issue pipeline  |
// |               register payload; IQ_DEPTH is the instantiated depth.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package instruction_queue_pkg;

   localparam int IQ_DEPTH = 8;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc;
      logic        prediction;
      logic        branch;
      logic        jump;
   } pipe_in_t;

endpackage
`default_nettype wire

// File: rtl/instruction_queue_ptr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iq_ptr                                                     |
// | Description : Wrapping pointer for the instruction queue. Advances by   |
// |               one on inc, wrapping naturally at 2**WIDTH. clr returns it |
// |               to zero and wins over inc.                                 |
// | Ports       : clk   - clock, rising edge                                 |
// |               reset - asynchronous active-high reset                     |
// |               inc   - advance pointer                                    |
// |               clr   - synchronous clear to zero (priority over inc)      |
// |               ptr   - current pointer value                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module iq_ptr #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] ptr
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/instruction_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instruction_queue                                          |
// | Description : Circular FIFO between the Fetch->Issue pipeline register   |
// |               and dispatch/rename. One-cycle latency, no fall-through,   |
// |               full decoded from registered occupancy only.               |
// | Ports       : clk        - clock, rising edge                            |
// |               reset      - asynchronous active-high reset                |
// |               flush      - synchronous clear of all entries              |
// |               in_valid   - enqueue request                               |
// |               in_data    - entry to enqueue                              |
// |               queue_full - occupancy == DEPTH (stalls upstream register) |
// |               out_valid  - head entry present                            |
// |               out_data   - head entry, zero when empty                   |
// |               out_ready  - consumer accepts head this cycle              |
// |               count      - current occupancy                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module instruction_queue
   import instruction_queue_pkg::*;
#(
   parameter  int DEPTH = IQ_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  pipe_in_t         in_data,
   output logic             queue_full,
   output logic             out_valid,
   output pipe_in_t         out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] occupancy;
   logic             enq;
   logic             deq;

   // Storage is not reset; occupancy alone decides what is visible.
   pipe_in_t mem [DEPTH];

   // Status decodes depend only on registered occupancy, never on inputs.
   assign queue_full = (occupancy == CNT_W'(DEPTH));
   assign out_valid  = (occupancy != '0);
   assign count      = occupancy;
   assign out_data   = out_valid ? mem[head] : '0;

   // A push while full is dropped even if a pop frees a slot this cycle;
   // the upstream register is stalled and will present it again.
   assign enq = in_valid  && !queue_full && !flush;
   assign deq = out_valid && out_ready   && !flush;

   iq_ptr #(.WIDTH(PTR_W)) u_head_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (deq),
      .clr   (flush),
      .ptr   (head)
   );

   iq_ptr #(.WIDTH(PTR_W)) u_tail_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (enq),
      .clr   (flush),
      .ptr   (tail)
   );

   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else if (enq && !deq) begin
         occupancy <= occupancy + CNT_W'(1);
      end else if (deq && !enq) begin
         occupancy <= occupancy - CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_instruction_queue                                       |
// | Description : Self-checking bench for instruction_queue. A queue-based  |
// |               reference model is compared against the DUT every cycle,  |
// |               and directed phases pin expected values by hand.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_instruction_queue;
   import instruction_queue_pkg::*;

   localparam int DEPTH = IQ_DEPTH;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset;
   logic             flush;
   logic             in_valid;
   pipe_in_t         in_data;
   logic             queue_full;
   logic             out_valid;
   pipe_in_t         out_data;
   logic             out_ready;
   logic [CNT_W-1:0] count;

   int checks   = 0;
   int failures = 0;

   instruction_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .queue_full (queue_full),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic pipe_in_t mk(input int pc);
      pipe_in_t e;
      e.instruction = 32'h0000_0013 + 32'(pc);
      e.pc          = 32'(pc);
      e.prediction  = pc[2];
      e.branch      = pc[3];
      e.jump        = pc[4];
      return e;
   endfunction

   function automatic logic [127:0] bits_of(input pipe_in_t e);
      logic [127:0] b;
      b = '0;
      b[$bits(pipe_in_t)-1:0] = e;
      return b;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: an ordered list of entries ----------
   pipe_in_t model_q[$];
   int       m_n;
   bit       m_push;
   bit       m_pop;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_q.delete();
      end else begin
         m_n    = model_q.size();
         m_push = in_valid && (m_n < DEPTH) && !flush;
         m_pop  = (m_n > 0) && out_ready && !flush;
         if (flush) begin
            model_q.delete();
         end else begin
            if (m_pop)  void'(model_q.pop_front());
            if (m_push) model_q.push_back(in_data);
         end
      end
   end

   // ---------------- per-cycle comparison ---------------------------------
   always @(negedge clk) begin
      pipe_in_t exp_head;
      int       sz;
      sz       = model_q.size();
      exp_head = (sz != 0) ? model_q[0] : '0;
      chk("model_count", 128'(count), 128'(sz));
      chk("model_out_valid", 128'(out_valid), 128'(sz != 0));
      chk("model_queue_full", 128'(queue_full), 128'(sz == DEPTH));
      chk("model_out_data", bits_of(out_data), bits_of(exp_head));
   end

   // ---------------- directed stimulus ------------------------------------
   task automatic step(input bit iv, input int pc, input bit rdy, input bit fl);
      in_valid  = iv;
      in_data   = iv ? mk(pc) : '0;
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic deq_chk(input string name, input int pc);
      chk(name, 128'(out_data.pc), 128'(pc));
      step(0, 0, 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int order_a[8];
      int order_b[7];
      order_a = '{32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30};
      order_b = '{32'h5C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70, 32'h78};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 0, 0);
      chk("reset_count", 128'(count), 128'(0));
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_queue_full", 128'(queue_full), 128'(0));
      chk("reset_out_data", bits_of(out_data), 128'(0));

      // Fill to full, then a dropped ninth push.
      for (int i = 0; i < 8; i++) step(1, i * 4, 0, 0);
      chk("fill_count", 128'(count), 128'(8));
      chk("fill_full", 128'(queue_full), 128'(1));
      step(1, 32'h20, 0, 0);
      chk("ninth_dropped_count", 128'(count), 128'(8));

      // Drain five, refill five (tail wraps), drain all.
      for (int i = 0; i < 5; i++) deq_chk("drain5_pc", i * 4);
      chk("drain5_count", 128'(count), 128'(3));
      for (int i = 0; i < 5; i++) step(1, 32'h20 + i * 4, 0, 0);
      chk("refill_count", 128'(count), 128'(8));
      for (int i = 0; i < 8; i++) deq_chk("wrap_order_pc", order_a[i]);
      chk("drained_count", 128'(count), 128'(0));
      chk("drained_out_data", bits_of(out_data), 128'(0));

      // Ready with an empty queue is ignored.
      step(0, 0, 1, 0);
      chk("empty_ready_count", 128'(count), 128'(0));

      // Simultaneous push/pop at count=3.
      step(1, 32'h50, 0, 0);
      chk("latency_head_pc", 128'(out_data.pc), 128'(32'h50));
      step(1, 32'h54, 0, 0);
      step(1, 32'h58, 0, 0);
      step(1, 32'h5C, 1, 0);
      chk("both3_count", 128'(count), 128'(3));
      chk("both3_head_pc", 128'(out_data.pc), 128'(32'h54));

      // Simultaneous push/pop at full: push dropped.
      for (int i = 0; i < 5; i++) step(1, 32'h60 + i * 4, 0, 0);
      chk("full_again", 128'(queue_full), 128'(1));
      step(1, 32'h74, 1, 0);
      chk("both_full_count", 128'(count), 128'(7));
      chk("both_full_head_pc", 128'(out_data.pc), 128'(32'h58));

      // Simultaneous push/pop at count=DEPTH-1.
      step(1, 32'h78, 1, 0);
      chk("both7_count", 128'(count), 128'(7));
      for (int i = 0; i < 7; i++) deq_chk("both_order_pc", order_b[i]);
      chk("both_drained", 128'(count), 128'(0));

      // Flush with concurrent push and pop.
      for (int i = 0; i < 5; i++) step(1, 32'h80 + i * 4, 0, 0);
      chk("preflush_count", 128'(count), 128'(5));
      step(1, 32'h94, 1, 1);
      chk("flush_count", 128'(count), 128'(0));
      chk("flush_out_valid", 128'(out_valid), 128'(0));
      chk("flush_out_data", bits_of(out_data), 128'(0));
      step(1, 32'h40, 0, 0);
      chk("postflush_head_pc", 128'(out_data.pc), 128'(32'h40));
      chk("postflush_count", 128'(count), 128'(1));

      // Flush while full.
      for (int i = 0; i < 7; i++) step(1, 32'hB0 + i * 4, 0, 0);
      chk("full_before_flush", 128'(queue_full), 128'(1));
      step(0, 0, 0, 1);
      chk("flush_full_clears", 128'(queue_full), 128'(0));

      // Asynchronous reset between edges with six entries.
      for (int i = 0; i < 6; i++) step(1, 32'h44 + i * 4, 0, 0);
      chk("prereset_count", 128'(count), 128'(6));
      step(0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_count", 128'(count), 128'(0));
      chk("async_out_valid", 128'(out_valid), 128'(0));
      chk("async_queue_full", 128'(queue_full), 128'(0));
      chk("async_out_data", bits_of(out_data), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      step(1, 32'hA0, 0, 0);
      chk("postreset_head_pc", 128'(out_data.pc), 128'(32'hA0));
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular FIFO directly downstream of the Fetch->Issue pipeline register.
- Buffers pipe_in_t entries (instruction, pc, prediction, branch, jump) between fetch and dispatch/rename.
- Drives queue_full back to the pipeline register, which holds its contents while queue_full=1.
- Flushed on branch/jump redirect or on commit of a mispredicted branch.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  enqueue request; top level drives it as (in_data.instruction != 0), because the pipeline register outputs all-zero bubbles.
- in_data  input  pipe_in_t  entry to enqueue.
- queue_full  output  1  high when count == DEPTH.
- out_valid  output  1  head entry present (count != 0).
- out_data  output  pipe_in_t  head entry; all-zero when out_valid=0.
- out_ready  input  1  consumer accepts head this cycle.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - head=0, tail=0, count=0.
  - queue_full=0, out_valid=0, out_data=0.
  - Storage contents need not be cleared.
- Enqueue fires when in_valid && !queue_full && !flush.
  - mem[tail] <= in_data; tail <= tail+1, wrapping DEPTH-1 -> 0.
- Dequeue fires when out_valid && out_ready && !flush.
  - head <= head+1, wrapping DEPTH-1 -> 0.
- count update per cycle:
  - +1 for enqueue only; -1 for dequeue only; unchanged when both or neither fire.
- Full:
  - queue_full is a function of the registered count only; no same-cycle bypass.
  - An enqueue attempt while full is dropped even if a dequeue fires that cycle. Upstream holds the data because the pipeline register is stalled.
- Empty:
  - out_valid=0; out_ready is ignored.
  - No fall-through: an entry enqueued at cycle N is visible on out_data at cycle N+1 at the earliest (1-cycle latency).
- Outputs:
  - out_data = mem[head] combinationally when count != 0, else 0.
  - out_valid, queue_full and count are combinational decodes of registered state and carry no same-cycle dependence on inputs.
- Flush has highest priority after reset.
  - Next cycle: head=tail=0, count=0; any enqueue or dequeue in the flush cycle is discarded.
  - Flush while full deasserts queue_full the next cycle.
- FIFO ordering is strict; entries are never reordered or dropped except by flush or reset.
- Pointer arithmetic: PTR_W-bit, modulo DEPTH (natural wrap, since DEPTH is a power of two).
- Simultaneous enqueue and dequeue at count=1 or count=DEPTH-1: count unchanged, both pointers advance.

Decomposition:
- Shared package structs.svh: pipe_in_t (already present), plus constant IQ_DEPTH = 8 used by the top-level instantiation.
- Sub-module iq_ptr:
  - PTR_W-bit wrapping pointer with inc, clr and async reset.
  - Instantiated twice, for head and tail.
- Storage and count stay in instruction_queue.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset high 2 cycles, then release.
  - Response: out_valid=0, queue_full=0, count=0, out_data=0.
- Fill to full:
  - Stimulus: 8 consecutive enqueues with pc=0x00,0x04,...,0x1C, out_ready=0; then a 9th with pc=0x20.
  - Response: count=8, queue_full=1 after the 8th; the 9th is dropped and count stays 8.
- Drain with wrap-around:
  - Stimulus: from 8 entries, dequeue 5 (pc 0x00..0x10), enqueue 5 (pc 0x20..0x30), then dequeue all.
  - Response: pc order 0x14,0x18,0x1C,0x20..0x30; tail has wrapped through 0.
- Simultaneous enqueue/dequeue:
  - At count=3, both fire: count stays 3 and the head advances.
  - At count=8, both fire: the enqueue is dropped and count becomes 7.
- Flush:
  - Stimulus: count=5 with flush=1, in_valid=1, out_ready=1 in the same cycle.
  - Response: next cycle count=0, out_valid=0; the flushed-cycle enqueue is absent; a following enqueue of pc=0x40 appears at the head.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges with count=6.
  - Response: out_valid, queue_full and count go to 0 immediately, before the next clk edge.
